// File: rtl/main_mem_responder.sv
// Main-memory responder for the cache controller.
// It accepts one line read or write, waits LATENCY cycles, then strobes ca_resp
// for RESP_CYCLES cycles. The data action happens on the edge that raises
// ca_resp. It then holds in DONE until the requester drops its request.
// The backing store has no reset, so line contents survive rst.
module main_mem_responder #(
    parameter int ADDR_W      = 6,
    parameter int LINE_W      = 256,
    parameter int LATENCY     = 4,
    parameter int RESP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata,
    output logic              ca_resp,
    output logic              busy,
    output logic              error
);

    localparam int CNT_MAX = (LATENCY > RESP_CYCLES) ? LATENCY : RESP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

    state_t              state_q, state_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ca_resp_q, ca_resp_d;
    logic                error_q, error_d;
    logic [LINE_W-1:0]   rdata_q;
    logic                commit;
    logic                req_held;

    logic [LINE_W-1:0]   store [2**ADDR_W];

    // The requester of the captured op must keep its own request line high.
    assign req_held = op_wr_q ? mem_write : mem_read;

    // Next-state, capture, counter, strobe and error decode
    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        ca_resp_d = 1'b0;
        error_d   = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write || mem_read) begin
                    // A simultaneous read and write is a protocol error. The write wins.
                    op_wr_d = mem_write;
                    addr_d  = line_addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_W'(LATENCY);
                    error_d = mem_write & mem_read;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!req_held) begin
                    // Request withdrawn before the action: abort and flag it.
                    state_d = IDLE;
                    cnt_d   = '0;
                    error_d = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d   = RESP;
                    cnt_d     = CNT_W'(RESP_CYCLES);
                    ca_resp_d = 1'b1;
                    commit    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (!req_held) begin
                    // Early end. The action is already committed, so this is not an error.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    ca_resp_d = 1'b1;
                end
            end
            DONE: begin
                if (!req_held) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers. rst discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            ca_resp_q <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            ca_resp_q <= ca_resp_d;
            error_q   <= error_d;
            if (commit && !op_wr_q) rdata_q <= store[addr_q];
        end
    end

    // The backing store has no reset. Writes land on the edge that raises ca_resp.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_wr_q) store[addr_q] <= wdata_q;
    end

    assign busy    = (state_q != IDLE);
    assign ca_resp = ca_resp_q;
    assign error   = error_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized scoreboard bench for main_mem_responder.
// u0 runs the default timing (LATENCY=4, RESP_CYCLES=2). u1 runs LATENCY=1, RESP_CYCLES=1.
// The driver plans each transaction with: accept cycle T, hold length H (request
// first sampled low at T+H) and an optional rst in cycle T+H. From these it derives:
// busy in T+1..T+H; an action only if H > LATENCY; ca_resp in
// T+LATENCY+1 .. T+LATENCY+min(RESP_CYCLES, H-LATENCY); error cycles.
module tb_main_mem_responder;
    localparam int AW = 6;
    localparam int LW = 256;

    typedef struct {int s; int e;} win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    // Cycle index, stepped on every rising edge
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]         rst_v, rd_v, wr_v;
    logic [1:0][AW-1:0] la_v;
    logic [1:0][LW-1:0] wd_v;
    wire  [1:0][LW-1:0] rd_o;
    wire  [1:0]         ca_v, bz_v, er_v;

    main_mem_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(4), .RESP_CYCLES(2)) u0 (
        .clk(clk), .rst(rst_v[0]), .mem_read(rd_v[0]), .mem_write(wr_v[0]),
        .line_addr(la_v[0]), .wdata(wd_v[0]), .rdata(rd_o[0]),
        .ca_resp(ca_v[0]), .busy(bz_v[0]), .error(er_v[0]));

    main_mem_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(1), .RESP_CYCLES(1)) u1 (
        .clk(clk), .rst(rst_v[1]), .mem_read(rd_v[1]), .mem_write(wr_v[1]),
        .line_addr(la_v[1]), .wdata(wd_v[1]), .rdata(rd_o[1]),
        .ca_resp(ca_v[1]), .busy(bz_v[1]), .error(er_v[1]));

    // Reference model state
    logic [LW-1:0] mem [2][64];
    bit            exp_busy [longint];
    logic [LW-1:0] exp_rd [longint];
    win_t          caq0[$], caq1[$];
    int            erq0[$], erq1[$];

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;
    bit  done   = 1'b0;

    function automatic int lat_of(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    function automatic int rc_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic longint key(input int c, input int g);
        return longint'(c) * 2 + longint'(g);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string nm, input int g, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d cyc=%0d got=%0h exp=%0h", nm, g, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_er(input int g, input int c);
        if (g == 0) erq0.push_back(c); else erq1.push_back(c);
    endtask

    task automatic push_ca(input int g, input win_t w);
        if (g == 0) caq0.push_back(w); else caq1.push_back(w);
    endtask

    // One transaction: the expectations come from the plan, then the pins are driven
    task automatic txn(input int g, input bit is_wr, input bit both, input int addr,
                       input logic [LW-1:0] data, input int h, input bit use_rst, input int gap);
        int t, lat, rc, n;
        win_t w;
        bit wr_op;
        lat   = lat_of(g);
        rc    = rc_of(g);
        wr_op = is_wr | both;
        repeat (gap) tick();
        t = cyc;
        wr_v[g] = wr_op;
        rd_v[g] = !is_wr | both;
        la_v[g] = AW'(addr);
        wd_v[g] = data;
        for (int i = 1; i <= h; i++) exp_busy[key(t + i, g)] = 1'b1;
        if (both) push_er(g, t + 1);
        if (h <= lat) begin
            if (!use_rst) push_er(g, t + h + 1);
        end else begin
            if (wr_op) mem[g][addr] = data;
            else       exp_rd[key(t + lat + 1, g)] = mem[g][addr];
            n   = (h - lat < rc) ? (h - lat) : rc;
            w.s = t + lat + 1;
            w.e = t + lat + n;
            push_ca(g, w);
        end
        if (use_rst) exp_rd[key(t + h + 1, g)] = '0;
        for (int i = 1; i < h; i++) begin
            tick();
            la_v[g] = AW'($urandom);
            wd_v[g] = rand_line();
        end
        tick();
        wr_v[g] = 1'b0;
        rd_v[g] = 1'b0;
        if (use_rst) rst_v[g] = 1'b1;
        tick();
        rst_v[g] = 1'b0;
    endtask

    // Stimulus
    initial begin
        int r;
        rst_v = '1; rd_v = '0; wr_v = '0; la_v = '0; wd_v = '0;
        repeat (3) tick();
        rst_v  = '0;
        chk_en = 1'b1;

        // u0: preload every line, then the directed cases, then random traffic
        for (int a = 0; a < 64; a++) txn(0, 1'b1, 1'b0, a, rand_line(), 7, 1'b0, 0);
        txn(0, 1'b1, 1'b0, 5, {32{8'hA5}}, 7, 1'b0, 0);
        txn(0, 1'b0, 1'b0, 5, '0, 8, 1'b0, 0);
        txn(0, 1'b0, 1'b0, 9, '0, 7, 1'b0, 1);
        txn(0, 1'b1, 1'b1, 3, rand_line(), 7, 1'b0, 0);
        txn(0, 1'b0, 1'b0, 3, '0, 7, 1'b0, 0);
        txn(0, 1'b1, 1'b0, 12, rand_line(), 2, 1'b0, 0);
        txn(0, 1'b0, 1'b0, 12, '0, 7, 1'b0, 0);
        txn(0, 1'b1, 1'b0, 20, rand_line(), 3, 1'b1, 0);
        txn(0, 1'b0, 1'b0, 20, '0, 7, 1'b0, 0);
        txn(0, 1'b1, 1'b0, 21, rand_line(), 9, 1'b1, 0);
        txn(0, 1'b0, 1'b0, 21, '0, 7, 1'b0, 2);
        repeat (150) begin
            r = $urandom_range(0, 15);
            txn(0, 1'($urandom_range(0, 1)), r == 0, $urandom_range(0, 63), rand_line(),
                $urandom_range(1, 9), r == 1, $urandom_range(0, 2));
        end

        // u1: short timing, including a requester that lingers in DONE
        for (int a = 0; a < 64; a++) txn(1, 1'b1, 1'b0, a, rand_line(), 3, 1'b0, 0);
        txn(1, 1'b1, 1'b0, 7, rand_line(), 5, 1'b0, 0);
        txn(1, 1'b0, 1'b0, 7, '0, 3, 1'b0, 0);
        repeat (100) begin
            r = $urandom_range(0, 15);
            txn(1, 1'($urandom_range(0, 1)), r == 0, $urandom_range(0, 63), rand_line(),
                $urandom_range(1, 5), r == 1, $urandom_range(0, 2));
        end

        repeat (4) tick();
        done = 1'b1;
    end

    // Monitor: per-cycle busy/rdata checks; ca_resp windows and error pulses come from the queues
    bit   [1:0]         prev_ca = '0;
    bit   [1:0]         have_w  = '0;
    logic [1:0][LW-1:0] cur_rd  = '0;
    win_t               cur_w [2];

    always @(negedge clk) begin : mon
        win_t   w;
        int     e;
        bit     got;
        longint k;
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                k = key(cyc, g);
                if (exp_rd.exists(k)) cur_rd[g] = exp_rd[k];
                check("rdata", g, rd_o[g], cur_rd[g]);
                check("busy", g, LW'(bz_v[g]), LW'(exp_busy.exists(k)));
                if (ca_v[g] && !prev_ca[g]) begin
                    got = 1'b0;
                    w.s = 0;
                    w.e = 0;
                    if (g == 0 && caq0.size() > 0) begin w = caq0.pop_front(); got = 1'b1; end
                    if (g == 1 && caq1.size() > 0) begin w = caq1.pop_front(); got = 1'b1; end
                    have_w[g] = got;
                    cur_w[g]  = w;
                    check("ca_rise_cycle", g, LW'(cyc), got ? LW'(w.s) : '1);
                end
                if (!ca_v[g] && prev_ca[g])
                    check("ca_fall_cycle", g, LW'(cyc - 1), have_w[g] ? LW'(cur_w[g].e) : '1);
                prev_ca[g] = ca_v[g];
                if (er_v[g]) begin
                    got = 1'b0;
                    e   = 0;
                    if (g == 0 && erq0.size() > 0) begin e = erq0.pop_front(); got = 1'b1; end
                    if (g == 1 && erq1.size() > 0) begin e = erq1.pop_front(); got = 1'b1; end
                    check("error_cycle", g, LW'(cyc), got ? LW'(e) : '1);
                end
            end
            if (done) begin
                check("ca_left", 0, LW'(caq0.size()), '0);
                check("ca_left", 1, LW'(caq1.size()), '0);
                check("err_left", 0, LW'(erq0.size()), '0);
                check("err_left", 1, LW'(erq1.size()), '0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

endmodule
